// File: rtl/bcd_down_timer.sv
// bcd_down_timer: multi-digit packed-BCD countdown timer with internal prescaler.
// Loads a clamped preset, borrows across digits once per prescaler tick, and
// stops at zero with a one-cycle done pulse.
// Optional feature macro: BCD_DOWN_TIMER_AUTO_RELOAD_EN (reload last preset on zero).
module bcd_down_timer #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   q,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned QW = 4 * DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t          state_q;
    logic [QW-1:0]   cnt_q;
    logic [PW-1:0]   pre_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic [QW-1:0]   load_clamp_d;
    logic            load_err_d;
    logic [QW-1:0]   cnt_dec_d;
    logic            tick_c;
    logic            cnt_zero_c;
    logic            cnt_one_c;

    assign tick_c     = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    assign cnt_zero_c = (cnt_q == '0);
    assign cnt_one_c  = (cnt_q == QW'(1));

    // Clamp each preset digit to 9 and flag whether any digit was out of range
    always_comb begin
        load_clamp_d = '0;
        load_err_d   = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clamp_d[4*i +: 4] = 4'd9;
                load_err_d             = 1'b1;
            end else begin
                load_clamp_d[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Borrow ripple: digit 0 borrows on tick, higher digits borrow past a zero digit
    always_comb begin
        logic       borrow;
        logic [3:0] digit;
        cnt_dec_d = cnt_q;
        borrow    = tick_c;
        digit     = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = cnt_q[4*i +: 4];
            if (borrow) begin
                cnt_dec_d[4*i +: 4] = (digit == 4'd0) ? 4'd9 : (digit - 4'd1);
            end
            borrow = borrow && (digit == 4'd0);
        end
    end

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    logic [QW-1:0] reload_q;

    // Remember the last clamped preset for automatic restart at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_clamp_d;
        end
    end
`endif

    // Control FSM, prescaler and count register; priority load > pause > start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                cnt_q   <= load_clamp_d;
                err_q   <= load_err_d;
                pre_q   <= '0;
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else if (pause && (state_q == ST_RUN)) begin
                state_q <= ST_PAUSE;
            end else if (start && (state_q != ST_RUN)) begin
                if (!cnt_zero_c) begin
                    // Resuming from PAUSE keeps the partial prescaler count
                    if (state_q != ST_PAUSE) begin
                        pre_q <= '0;
                    end
                    state_q <= ST_RUN;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else if (state_q == ST_RUN) begin
                if (tick_c) begin
                    pre_q <= '0;
                    if (cnt_one_c) begin
                        // Final step: never borrow below zero
                        done_q <= 1'b1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
                        if (reload_q != '0) begin
                            cnt_q <= reload_q;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end
`else
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_dec_d;
                    end
                end else begin
                    pre_q <= pre_q + PW'(1);
                end
            end
        end
    end

    assign q    = cnt_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: integer-valued reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bcd_down_timer;

    localparam int unsigned DIGITS   = 2;
    localparam int unsigned TICK_DIV = 3;
    localparam int unsigned QW       = 4 * DIGITS;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [QW-1:0] load_val = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [QW-1:0] q;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    bcd_down_timer #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: count held as a plain integer, phases as small codes
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_val = 0, m_presc = 0, m_st = M_IDLE, m_reload = 0;
    bit m_done = 1'b0, m_err = 1'b0, m_busy = 1'b0;
    bit chk_en = 1'b0;

    function automatic void clamp(input logic [QW-1:0] v, output int val, output bit e);
        int p;
        int d;
        val = 0;
        e   = 1'b0;
        p   = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) begin
                d = 9;
                e = 1'b1;
            end
            val += d * p;
            p   *= 10;
        end
    endfunction

    function automatic logic [QW-1:0] to_bcd(input int v);
        logic [QW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_val = 0; m_presc = 0; m_st = M_IDLE; m_reload = 0;
            m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            if (load) begin
                clamp(load_val, m_val, m_err);
                m_reload = m_val;
                m_presc  = 0;
                m_st     = M_IDLE;
            end else if (pause && m_st == M_RUN) begin
                m_st = M_PAUSE;
            end else if (start && m_st != M_RUN) begin
                if (m_val != 0) begin
                    if (m_st != M_PAUSE) m_presc = 0;
                    m_st = M_RUN;
                end else begin
                    m_st   = M_DONE;
                    m_done = 1'b1;
                end
            end else if (m_st == M_RUN) begin
                if (m_presc == int'(TICK_DIV) - 1) begin
                    m_presc = 0;
                    if (m_val == 1) begin
                        m_done = 1'b1;
                        if (AR && m_reload != 0) begin
                            m_val = m_reload;
                        end else begin
                            m_val = 0;
                            m_st  = M_DONE;
                        end
                    end else begin
                        m_val = m_val - 1;
                    end
                end else begin
                    m_presc++;
                end
            end
        end
        m_busy = (m_st == M_RUN) || (m_st == M_PAUSE);
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model_q",    32'(q),    32'(to_bcd(m_val)));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_done", 32'(done), 32'(m_done));
            check("model_err",  32'(err),  32'(m_err));
        end
    end

    // Strobes: called at a negedge, high for exactly one rising edge
    task automatic do_load(input logic [QW-1:0] v);
        load = 1'b1; load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int done_cnt;
        int done_at;

        // Reset state
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_q", 32'(q), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Count 12 down to 00; a stray start mid-run is ignored
        do_load(8'h12);
        do_start();
        done_cnt = 0;
        done_at  = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 9);
            if (k == 3) check("cnt12_first_step", 32'(q), 32'h11);
            if (k == 30) check("cnt12_k30", 32'(q), 32'h02);
            if (done) begin
                done_cnt++;
                done_at = k;
                check("cnt12_q_at_done", 32'(q), 32'h00);
                check("cnt12_busy_at_done", 32'(busy), 32'h0);
            end
        end
        start = 1'b0;
        check("cnt12_done_count", 32'(done_cnt), 32'd1);
        check("cnt12_done_cycle", 32'(done_at), 32'd36);

        // Clamping and sticky error
        do_load(8'h1F);
        check("clamp_q", 32'(q), 32'h19);
        check("clamp_err", 32'(err), 32'h1);
        do_load(8'h05);
        check("clean_q", 32'(q), 32'h05);
        check("clean_err", 32'(err), 32'h0);

        // Pause holds count and prescaler, resume keeps prescaler phase
        do_load(8'h20);
        do_start();
        repeat (3) @(negedge clk);
        check("pause_pre_q", 32'(q), 32'h19);
        do_pause();
        repeat (20) @(negedge clk);
        check("pause_hold_q", 32'(q), 32'h19);
        check("pause_busy", 32'(busy), 32'h1);
        do_start();
        repeat (2) @(negedge clk);
        check("resume_q_before", 32'(q), 32'h19);
        @(negedge clk);
        check("resume_q_step", 32'(q), 32'h18);

        // Start with zero count goes straight to DONE
        do_load(8'h00);
        do_start();
        check("zero_done", 32'(done), 32'h1);
        check("zero_busy", 32'(busy), 32'h0);
        check("zero_q", 32'(q), 32'h00);
        @(negedge clk);
        check("zero_done_pulse_end", 32'(done), 32'h0);

        // Reset mid-run clears everything including err
        do_load(8'h0A);
        check("clampA_q", 32'(q), 32'h09);
        check("clampA_err", 32'(err), 32'h1);
        do_start();
        repeat (6) @(negedge clk);
        check("midrun_q", 32'(q), 32'h07);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_q", 32'(q), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        do_start();
        check("postrst_start_done", 32'(done), 32'h1);
        check("postrst_start_busy", 32'(busy), 32'h0);

        // Load coinciding with the final tick wins: no done pulse
        do_load(8'h01);
        do_start();
        repeat (2) @(negedge clk);
        load = 1'b1; load_val = 8'h33;
        @(negedge clk);
        load = 1'b0;
        check("ldtick_q", 32'(q), 32'h33);
        check("ldtick_done", 32'(done), 32'h0);
        check("ldtick_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("ldtick_done_after", 32'(done), 32'h0);

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        // Auto reload: 02,01,02(done),01,02(done)... busy never drops
        do_load(8'h02);
        do_start();
        done_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check("ar_busy", 32'(busy), 32'h1);
            if (k == 3) check("ar_q_k3", 32'(q), 32'h01);
            if (k == 6) check("ar_q_k6", 32'(q), 32'h02);
            if (done) done_cnt++;
        end
        check("ar_done_count", 32'(done_cnt), 32'd2);
        do_load(8'h00);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
